// File: rtl/accum_result_collector.sv
// Result collector for an add/subtract accumulator: queues sampled {ovf, carry, sum}
// words in a small FIFO and tracks sticky carry/overflow flags plus a saturating overflow count.
module accum_result_collector #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_sample,
    input  logic [7:0]                 i_sum,
    input  logic                       i_carry,
    input  logic                       i_ovf,
    input  logic                       i_clr_flags,
    input  logic                       i_ready,
    output logic                       o_valid,
    output logic [9:0]                 o_data,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_full,
    output logic                       o_drop,
    output logic                       o_ovf_sticky,
    output logic                       o_carry_sticky,
    output logic [CNT_W-1:0]           o_ovf_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [9:0]       mem [0:DEPTH-1];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic             pop;
    logic             push;
    logic             drop_next;
    logic [9:0]       word;
    logic [PTR_W-1:0] wr_next;
    logic [PTR_W-1:0] rd_next;
    logic [LVL_W-1:0] level_next;
    logic [9:0]       head_next;
    logic [CNT_W-1:0] cnt_next;
    logic             ovf_sticky_next;
    logic             carry_sticky_next;

    // Next-state for the FIFO pointers, occupancy, registered head word and event flags
    always_comb begin
        pop       = o_valid & i_ready;
        push      = i_sample & (~o_full | pop);
        drop_next = i_sample & o_full & ~pop;
        word      = {i_ovf, i_carry, i_sum};

        if (push) begin
            wr_next = wr_ptr + PTR_W'(1);
        end else begin
            wr_next = wr_ptr;
        end

        if (pop) begin
            rd_next = rd_ptr + PTR_W'(1);
        end else begin
            rd_next = rd_ptr;
        end

        case ({push, pop})
            2'b10:   level_next = o_level + LVL_W'(1);
            2'b01:   level_next = o_level - LVL_W'(1);
            default: level_next = o_level;
        endcase

        // The new head may be the word being written on this very edge.
        if (level_next == LVL_W'(0)) begin
            head_next = 10'h000;
        end else if (push && (wr_ptr == rd_next)) begin
            head_next = word;
        end else begin
            head_next = mem[rd_next];
        end

        // A sampled event wins over a same-cycle clear.
        if (i_sample && i_ovf) begin
            ovf_sticky_next = 1'b1;
            if (i_clr_flags) begin
                cnt_next = CNT_W'(1);
            end else if (o_ovf_cnt != {CNT_W{1'b1}}) begin
                cnt_next = o_ovf_cnt + CNT_W'(1);
            end else begin
                cnt_next = o_ovf_cnt;
            end
        end else if (i_clr_flags) begin
            ovf_sticky_next = 1'b0;
            cnt_next        = {CNT_W{1'b0}};
        end else begin
            ovf_sticky_next = o_ovf_sticky;
            cnt_next        = o_ovf_cnt;
        end

        if (i_sample && i_carry) begin
            carry_sticky_next = 1'b1;
        end else if (i_clr_flags) begin
            carry_sticky_next = 1'b0;
        end else begin
            carry_sticky_next = o_carry_sticky;
        end
    end

    // Storage array; contents need no reset since visibility is governed by the pointers
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= word;
        end
    end

    // Control state and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr         <= {PTR_W{1'b0}};
            rd_ptr         <= {PTR_W{1'b0}};
            o_level        <= {LVL_W{1'b0}};
            o_valid        <= 1'b0;
            o_full         <= 1'b0;
            o_data         <= 10'h000;
            o_drop         <= 1'b0;
            o_ovf_sticky   <= 1'b0;
            o_carry_sticky <= 1'b0;
            o_ovf_cnt      <= {CNT_W{1'b0}};
        end else begin
            wr_ptr         <= wr_next;
            rd_ptr         <= rd_next;
            o_level        <= level_next;
            o_valid        <= (level_next != LVL_W'(0));
            o_full         <= (level_next == LVL_W'(DEPTH));
            o_data         <= head_next;
            o_drop         <= drop_next;
            o_ovf_sticky   <= ovf_sticky_next;
            o_carry_sticky <= carry_sticky_next;
            o_ovf_cnt      <= cnt_next;
        end
    end

endmodule

// File: tb/tb_accum_result_collector.sv
// Directed bench for accum_result_collector: a scoreboard queue of expected FIFO words
// checked by a monitor at every pop, plus direct checks of level, flags and counters.
module tb_accum_result_collector;

    logic       clk = 1'b0;
    logic       rst;
    logic       sample;
    logic [7:0] sum;
    logic       carry;
    logic       ovf;
    logic       clr;
    logic       ready;

    logic       valid_a, full_a, drop_a, ovs_a, cys_a;
    logic [9:0] data_a;
    logic [2:0] level_a;
    logic [7:0] cnt_a;

    logic       valid_b, full_b, drop_b, ovs_b, cys_b;
    logic [9:0] data_b;
    logic [2:0] level_b;
    logic [1:0] cnt_b;

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q [$];

    always #5 clk = ~clk;

    accum_result_collector #(.DEPTH(4), .CNT_W(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_sample(sample), .i_sum(sum), .i_carry(carry),
        .i_ovf(ovf), .i_clr_flags(clr), .i_ready(ready),
        .o_valid(valid_a), .o_data(data_a), .o_level(level_a), .o_full(full_a),
        .o_drop(drop_a), .o_ovf_sticky(ovs_a), .o_carry_sticky(cys_a), .o_ovf_cnt(cnt_a)
    );

    accum_result_collector #(.DEPTH(4), .CNT_W(2)) dut_sat (
        .i_clk(clk), .i_rst(rst), .i_sample(sample), .i_sum(sum), .i_carry(carry),
        .i_ovf(ovf), .i_clr_flags(clr), .i_ready(ready),
        .o_valid(valid_b), .o_data(data_b), .o_level(level_b), .o_full(full_b),
        .o_drop(drop_b), .o_ovf_sticky(ovs_b), .o_carry_sticky(cys_b), .o_ovf_cnt(cnt_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one sample for a single cycle; record the word if it is expected to enter the FIFO
    task automatic do_sample(input logic [7:0] s, input logic c, input logic o, input logic pushes);
        sample = 1'b1;
        sum    = s;
        carry  = c;
        ovf    = o;
        if (pushes) exp_q.push_back({o, c, s});
        tick();
        sample = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, 32'(valid_a), 32'd0);
        chk({tag, "_data"},  32'(data_a),  32'h000);
        chk({tag, "_level"}, 32'(level_a), 32'd0);
        chk({tag, "_full"},  32'(full_a),  32'd0);
        chk({tag, "_drop"},  32'(drop_a),  32'd0);
        chk({tag, "_ovfs"},  32'(ovs_a),   32'd0);
        chk({tag, "_cys"},   32'(cys_a),   32'd0);
        chk({tag, "_cnt"},   32'(cnt_a),   32'd0);
        chk({tag, "_cnt2"},  32'(cnt_b),   32'd0);
    endtask

    // Scoreboard monitor: a pop happens at the coming edge, so the head must match the queue front
    always @(negedge clk) begin
        if (!rst && valid_a && ready) begin
            if (exp_q.size() == 0) begin
                chk("pop_unexpected", 32'(data_a), 32'h3FF);
            end else begin
                chk("pop_data", 32'(data_a), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rst = 1'b1; sample = 1'b0; sum = 8'h00; carry = 1'b0; ovf = 1'b0;
        clr = 1'b0; ready = 1'b0;
        tick();
        tick();
        chk_reset_state("rst");
        rst = 1'b0;

        // Single-sample latency
        do_sample(8'h7F, 1'b0, 1'b0, 1'b1);
        chk("lat_valid", 32'(valid_a), 32'd1);
        chk("lat_data",  32'(data_a),  32'h07F);
        chk("lat_level", 32'(level_a), 32'd1);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("lat_empty", 32'(valid_a), 32'd0);

        // Fill to full with ready low, fifth sample dropped
        for (int i = 1; i <= 5; i++) begin
            do_sample(8'(i), 1'b0, 1'b0, (i <= 4) ? 1'b1 : 1'b0);
            if (i == 4) begin
                chk("fill_full",  32'(full_a),  32'd1);
                chk("fill_level", 32'(level_a), 32'd4);
                chk("fill_nodrop", 32'(drop_a), 32'd0);
            end
        end
        chk("drop_pulse", 32'(drop_a),  32'd1);
        chk("drop_level", 32'(level_a), 32'd4);
        chk("hold_data",  32'(data_a),  32'h001);
        tick();
        chk("drop_end",   32'(drop_a),  32'd0);
        chk("hold_data2", 32'(data_a),  32'h001);

        // Push while full with a simultaneous pop
        ready = 1'b1;
        do_sample(8'h10, 1'b0, 1'b0, 1'b1);
        chk("pp_level", 32'(level_a), 32'd4);
        chk("pp_drop",  32'(drop_a),  32'd0);
        chk("pp_full",  32'(full_a),  32'd1);
        for (int i = 0; i < 4; i++) tick();
        chk("drain_valid", 32'(valid_a), 32'd0);
        chk("drain_level", 32'(level_a), 32'd0);

        // Sticky flags and overflow counter, FIFO draining continuously
        do_sample(8'h80, 1'b1, 1'b1, 1'b1);
        do_sample(8'h81, 1'b0, 1'b1, 1'b1);
        do_sample(8'h82, 1'b0, 1'b1, 1'b1);
        chk("ovf3_cnt",  32'(cnt_a), 32'd3);
        chk("ovf3_cnt2", 32'(cnt_b), 32'd3);
        chk("ovf3_ovs",  32'(ovs_a), 32'd1);
        chk("ovf3_cys",  32'(cys_a), 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_cnt", 32'(cnt_a), 32'd0);
        chk("clr_ovs", 32'(ovs_a), 32'd0);
        chk("clr_cys", 32'(cys_a), 32'd0);
        clr = 1'b1;
        do_sample(8'h90, 1'b0, 1'b1, 1'b1);
        clr = 1'b0;
        chk("clrsam_cnt",  32'(cnt_a), 32'd1);
        chk("clrsam_ovs",  32'(ovs_a), 32'd1);
        chk("clrsam_cys",  32'(cys_a), 32'd0);
        chk("clrsam_cnt2", 32'(cnt_b), 32'd1);

        // Saturation on the 2-bit counter instance
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 5; i++) do_sample(8'hA0 + 8'(i), 1'b0, 1'b1, 1'b1);
        chk("sat_cnt2", 32'(cnt_b), 32'd3);
        chk("sat_cnt",  32'(cnt_a), 32'd5);
        tick();
        ready = 1'b0;
        chk("sat_empty", 32'(valid_a), 32'd0);

        // Reset in the middle of a drain
        do_sample(8'h11, 1'b0, 1'b0, 1'b1);
        do_sample(8'h22, 1'b1, 1'b0, 1'b1);
        do_sample(8'h33, 1'b0, 1'b1, 1'b1);
        chk("pre_rst_level", 32'(level_a), 32'd3);
        ready = 1'b1;
        tick();
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        ready = 1'b0;
        chk_reset_state("mid_rst");
        do_sample(8'hAA, 1'b0, 1'b0, 1'b1);
        chk("post_rst_data",  32'(data_a),  32'h0AA);
        chk("post_rst_level", 32'(level_a), 32'd1);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("post_rst_empty", 32'(valid_a), 32'd0);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
